// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if -- instruction-cache fetch handshake.
//
// Carries the request/response pair between the fetch stage (master) and the
// instruction cache (slave):
//   ICACHE_ren    master->slave  fetch request
//   ICACHE_addr   master->slave  fetch byte address
//   ICACHE_stall  slave->master  cache busy; rdata valid when ren=1, stall=0
//   ICACHE_rdata  slave->master  fetched instruction word
// ---------------------------------------------------------------------------
interface if_stage_if #(
  parameter int BITS = 32
) ();

  logic            ICACHE_ren;
  logic [BITS-1:0] ICACHE_addr;
  logic            ICACHE_stall;
  logic [BITS-1:0] ICACHE_rdata;

  modport master (
    output ICACHE_ren,
    output ICACHE_addr,
    input  ICACHE_stall,
    input  ICACHE_rdata
  );

  modport slave (
    input  ICACHE_ren,
    input  ICACHE_addr,
    output ICACHE_stall,
    output ICACHE_rdata
  );

endinterface : if_stage_if

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- RV32I instruction fetch stage plus IF/ID pipeline register.
//
// Owns the PC, runs the stall handshake with the instruction cache, absorbs
// ID stalls in a one-entry skid buffer and applies EX redirects.
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   icache              if_stage_if.master: ren/addr out, stall/rdata in
//   stall_id            ID/hazard stall, holds IF/ID
//   redirect/_pc        taken branch/jump from EX and its target
//   ifid_valid/pc/pc_plus4/instr   registered IF/ID contents
//   Opcode/Funct3/Funct7           combinational slices of ifid_instr
//   perf_stall_cnt/perf_flush_cnt  performance counters
//
// Configuration:
//   IF_PERF_CNT_EN  when defined, perf_stall_cnt counts cycles with ren=1 and
//                   ICACHE_stall=1, perf_flush_cnt counts redirect cycles;
//                   both saturate. When undefined both ports read 0 and no
//                   counter flops are built.
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [BITS-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  if_stage_if.master      icache,
  input  logic            stall_id,
  input  logic            redirect,
  input  logic [BITS-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [BITS-1:0] ifid_pc,
  output logic [BITS-1:0] ifid_pc_plus4,
  output logic [BITS-1:0] ifid_instr,
  output logic [6:0]      Opcode,
  output logic [2:0]      Funct3,
  output logic [6:0]      Funct7,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
);

  localparam logic [1:0] S_IDLE  = 2'd0;  // one dead cycle after reset
  localparam logic [1:0] S_FETCH = 2'd1;  // requesting pc
  localparam logic [1:0] S_HOLD  = 2'd2;  // skid buffer full, ID stalled
  localparam logic [1:0] S_DRAIN = 2'd3;  // finishing an abandoned access

  localparam logic [BITS-1:0] PC_STEP = BITS'(4);

  logic [1:0]      state;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] pending_pc;   // redirect target waiting for DRAIN to end
  logic [BITS-1:0] skid_pc;
  logic [BITS-1:0] skid_instr;
  logic [BITS-1:0] redirect_target;
  logic            access_busy;

  // Instructions are word aligned, so the low target bits are ignored.
  assign redirect_target = {redirect_pc[BITS-1:2], 2'b00};

  // A request is outstanding in FETCH and DRAIN. The address is simply the
  // PC register, so it only ever moves on a clock edge and stays put while
  // the cache is stalled or an abandoned access drains.
  assign icache.ICACHE_ren  = (state == S_FETCH) || (state == S_DRAIN);
  assign icache.ICACHE_addr = pc;
  assign access_busy        = icache.ICACHE_ren && icache.ICACHE_stall;

  // NOTE: async reset drops ren to 0 at once, abandoning any access in flight;
  // the IDLE cycle after release keeps a stale cache response from being used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      pending_pc    <= '0;
      // NOTE: the skid registers are reset too, even though occupancy is
      // implied by state==HOLD, so no X ever reaches IF/ID.
      skid_pc       <= '0;
      skid_instr    <= '0;
      ifid_valid    <= 1'b0;
      ifid_pc       <= RESET_PC;
      ifid_pc_plus4 <= RESET_PC + PC_STEP;
      ifid_instr    <= NOP_INSTR;
    end else if (redirect) begin
      // Redirect beats everything, including stall_id: flush IF/ID and drop
      // the skid buffer by leaving HOLD. If the cache still owes us a word,
      // wait it out in DRAIN before fetching the target.
      // NOTE: non-blocking assignments everywhere in sequential logic, so
      // every register sees pre-edge values regardless of statement order.
      ifid_valid <= 1'b0;
      ifid_instr <= NOP_INSTR;
      if (access_busy) begin
        pending_pc <= redirect_target;
        state      <= S_DRAIN;
      end else begin
        pc    <= redirect_target;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;

        S_FETCH: begin
          if (!icache.ICACHE_stall) begin
            if (stall_id) begin
              skid_pc    <= pc;
              skid_instr <= icache.ICACHE_rdata;
              state      <= S_HOLD;
            end else begin
              ifid_valid    <= 1'b1;
              ifid_pc       <= pc;
              ifid_pc_plus4 <= pc + PC_STEP;
              ifid_instr    <= icache.ICACHE_rdata;
              pc            <= pc + PC_STEP;
            end
          end
        end

        S_HOLD: begin
          if (!stall_id) begin
            ifid_valid    <= 1'b1;
            ifid_pc       <= skid_pc;
            ifid_pc_plus4 <= skid_pc + PC_STEP;
            ifid_instr    <= skid_instr;
            pc            <= skid_pc + PC_STEP;
            state         <= S_FETCH;
          end
        end

        S_DRAIN: begin
          // The returned word belongs to the old path and is dropped.
          if (!icache.ICACHE_stall) begin
            pc    <= pending_pc;
            state <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // A bubble decodes as addi x0,x0,0 and therefore writes nothing.
  assign Opcode = ifid_instr[6:0];
  assign Funct3 = ifid_instr[14:12];
  assign Funct7 = ifid_instr[31:25];

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (access_busy && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      if (redirect    && (flush_cnt != '1)) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign perf_stall_cnt = stall_cnt;
  assign perf_flush_cnt = flush_cnt;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule : if_stage

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
//
// A directed vector table covers the straight-line fetch, cache-stall and
// ID-stall cases; hand-written sequences cover redirects, PC wrap and reset
// mid-access; a long random run is compared against a transaction-level
// reference model (next-fetch PC, a discard flag and a holding queue).
// ---------------------------------------------------------------------------
module tb_if_stage;

`ifdef IF_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_id = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic [6:0]  Opcode, Funct7;
  logic [2:0]  Funct3;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  if_stage_if #(.BITS(32)) icache ();

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .icache        (icache),
    .stall_id      (stall_id),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .ifid_valid    (ifid_valid),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_instr    (ifid_instr),
    .Opcode        (Opcode),
    .Funct3        (Funct3),
    .Funct7        (Funct7),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } word_t;

  bit          m_startup;   // first cycle after reset: no request yet
  logic [31:0] m_pc;        // address of the next word to fetch
  bit          m_discard;   // outstanding access belongs to a dead path
  logic [31:0] m_pend;      // where to go once the dead access returns
  word_t       m_held[$];   // word fetched while ID was stalled
  bit          m_valid;
  logic [31:0] m_ifid_pc, m_ifid_instr;
  longint      m_stall_cnt, m_flush_cnt;

  task automatic model_reset();
    m_startup = 1'b1;
    m_pc = 32'h0;
    m_discard = 1'b0;
    m_pend = 32'h0;
    m_held.delete();
    m_valid = 1'b0;
    m_ifid_pc = 32'h0;
    m_ifid_instr = NOP;
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  function automatic bit model_ren();
    return !m_startup && (m_held.size() == 0);
  endfunction

  function automatic logic [31:0] sat(input longint c);
    return (c > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : c[31:0];
  endfunction

  task automatic model_step(input bit st, input bit sid, input bit rd,
                            input logic [31:0] rpc, input logic [31:0] data);
    bit ren = model_ren();
    word_t w;
    if (ren && st) m_stall_cnt++;
    if (rd) begin
      m_flush_cnt++;
      m_valid = 1'b0;
      m_ifid_instr = NOP;
      m_held.delete();
      m_startup = 1'b0;
      if (ren && st) begin
        m_discard = 1'b1;
        m_pend = {rpc[31:2], 2'b00};
      end else begin
        m_discard = 1'b0;
        m_pc = {rpc[31:2], 2'b00};
      end
    end else if (m_startup) begin
      m_startup = 1'b0;
    end else if (m_held.size() != 0) begin
      if (!sid) begin
        w = m_held.pop_front();
        m_valid = 1'b1;
        m_ifid_pc = w.pc;
        m_ifid_instr = w.instr;
        m_pc = w.pc + 32'd4;
      end
    end else if (!st) begin
      if (m_discard) begin
        m_discard = 1'b0;
        m_pc = m_pend;
      end else if (sid) begin
        w.pc = m_pc;
        w.instr = data;
        m_held.push_back(w);
      end else begin
        m_valid = 1'b1;
        m_ifid_pc = m_pc;
        m_ifid_instr = data;
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    check("m_ren",    32'(icache.ICACHE_ren), 32'(model_ren()));
    check("m_addr",   icache.ICACHE_addr, m_pc);
    check("m_valid",  32'(ifid_valid), 32'(m_valid));
    check("m_pc",     ifid_pc, m_ifid_pc);
    check("m_pc4",    ifid_pc_plus4, m_ifid_pc + 32'd4);
    check("m_instr",  ifid_instr, m_ifid_instr);
    check("m_opcode", 32'(Opcode), 32'(m_ifid_instr[6:0]));
    check("m_funct3", 32'(Funct3), 32'(m_ifid_instr[14:12]));
    check("m_funct7", 32'(Funct7), 32'(m_ifid_instr[31:25]));
    check("m_pstall", perf_stall_cnt, PERF ? sat(m_stall_cnt) : 32'h0);
    check("m_pflush", perf_flush_cnt, PERF ? sat(m_flush_cnt) : 32'h0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model,
  // then compare at the next falling edge.
  task automatic cycle(input bit st, input bit sid, input bit rd,
                       input logic [31:0] rpc, input logic [31:0] data);
    icache.ICACHE_stall = st;
    icache.ICACHE_rdata = data;
    stall_id = sid;
    redirect = rd;
    redirect_pc = rpc;
    model_step(st, sid, rd, rpc, data);
    @(negedge clk);
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  // Each row: expected outputs seen at this falling edge, then inputs driven
  // for the following rising edge.
  typedef struct {
    bit          st;
    bit          sid;
    logic [31:0] data;
    bit          e_ren;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  initial begin
    logic [31:0] r0, r1, r2, r3, r10, r14, r18, r1c, r20, r24;
    r0 = 32'h00A0_0093; r1 = 32'h0010_0113; r2 = 32'h0020_81B3;
    r3 = 32'h0030_8213; r10 = 32'h0040_0293; r14 = 32'h0050_0313;
    r18 = 32'h0060_0393; r1c = 32'h0070_0413; r20 = 32'h0080_0493;
    r24 = 32'h0090_0513;
    //           st sid data   ren addr       v  ifid_pc    instr
    vecs[0]  = '{0, 0, 32'h0, 0, 32'h00, 0, 32'h00, NOP};  // IDLE
    vecs[1]  = '{0, 0, r0,    1, 32'h00, 0, 32'h00, NOP};
    vecs[2]  = '{0, 0, r1,    1, 32'h04, 1, 32'h00, r0};
    vecs[3]  = '{0, 0, r2,    1, 32'h08, 1, 32'h04, r1};
    vecs[4]  = '{0, 0, r3,    1, 32'h0C, 1, 32'h08, r2};
    vecs[5]  = '{1, 0, 32'h0, 1, 32'h10, 1, 32'h0C, r3};   // cache stall x3
    vecs[6]  = '{1, 0, 32'h0, 1, 32'h10, 1, 32'h0C, r3};
    vecs[7]  = '{1, 0, 32'h0, 1, 32'h10, 1, 32'h0C, r3};
    vecs[8]  = '{0, 0, r10,   1, 32'h10, 1, 32'h0C, r3};
    vecs[9]  = '{0, 0, r14,   1, 32'h14, 1, 32'h10, r10};
    vecs[10] = '{0, 0, r18,   1, 32'h18, 1, 32'h14, r14};
    vecs[11] = '{0, 0, r1c,   1, 32'h1C, 1, 32'h18, r18};
    vecs[12] = '{0, 1, r20,   1, 32'h20, 1, 32'h1C, r1c};  // ID stall x2
    vecs[13] = '{0, 1, 32'h0, 0, 32'h20, 1, 32'h1C, r1c};
    vecs[14] = '{0, 0, 32'h0, 0, 32'h20, 1, 32'h1C, r1c};
    vecs[15] = '{0, 0, r24,   1, 32'h24, 1, 32'h20, r20};
    vecs[16] = '{0, 0, 32'h0, 1, 32'h28, 1, 32'h24, r24};

    icache.ICACHE_stall = 1'b0;
    icache.ICACHE_rdata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ren", 32'(icache.ICACHE_ren), 32'h0);
    check("rst_pc4", ifid_pc_plus4, 32'h4);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      check($sformatf("v%0d_ren", i),   32'(icache.ICACHE_ren), 32'(vecs[i].e_ren));
      check($sformatf("v%0d_addr", i),  icache.ICACHE_addr, vecs[i].e_addr);
      check($sformatf("v%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
      check($sformatf("v%0d_pc", i),    ifid_pc, vecs[i].e_pc);
      check($sformatf("v%0d_instr", i), ifid_instr, vecs[i].e_instr);
      check($sformatf("v%0d_op", i),    32'(Opcode), 32'(vecs[i].e_instr[6:0]));
      cycle(vecs[i].st, vecs[i].sid, 1'b0, 32'h0, vecs[i].data);
    end
    check("perf_stall_3", perf_stall_cnt, PERF ? 32'd3 : 32'd0);

    // ---- redirect to 0x103 while the cache is stalled on 0x40 ----
    cycle(0, 0, 1, 32'h40, 32'h0);
    check("rd40_addr", icache.ICACHE_addr, 32'h40);
    cycle(1, 0, 0, 32'h0, 32'h0);
    cycle(1, 0, 1, 32'h103, 32'h0);
    check("drain_ren",   32'(icache.ICACHE_ren), 32'h1);
    check("drain_addr",  icache.ICACHE_addr, 32'h40);
    check("flush_valid", 32'(ifid_valid), 32'h0);
    check("flush_instr", ifid_instr, NOP);
    cycle(0, 0, 0, 32'h0, 32'hDEAD_BEEF);
    check("tgt_addr",  icache.ICACHE_addr, 32'h100);
    check("tgt_valid", 32'(ifid_valid), 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h00A0_0093);
    check("tgt_ifpc",  ifid_pc, 32'h100);
    check("tgt_instr", ifid_instr, 32'h00A0_0093);

    // ---- redirect together with stall_id ----
    cycle(0, 1, 1, 32'h200, 32'h1111_1111);
    check("rs_valid", 32'(ifid_valid), 32'h0);
    check("rs_instr", ifid_instr, NOP);
    check("rs_ren",   32'(icache.ICACHE_ren), 32'h1);
    check("rs_addr",  icache.ICACHE_addr, 32'h200);
    cycle(0, 0, 0, 32'h0, 32'h0010_0113);
    check("rs_ifpc",  ifid_pc, 32'h200);

    // ---- PC wrap ----
    cycle(0, 0, 1, 32'hFFFF_FFFC, 32'h0);
    check("wrap_addr0", icache.ICACHE_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 32'h0, 32'h0020_81B3);
    check("wrap_addr1", icache.ICACHE_addr, 32'h0);
    check("wrap_ifpc",  ifid_pc, 32'hFFFF_FFFC);
    check("wrap_pc4",   ifid_pc_plus4, 32'h0);

    // ---- reset asserted mid-stall ----
    cycle(0, 0, 1, 32'h80, 32'h0);
    cycle(1, 0, 0, 32'h0, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    check("mrst_ren",   32'(icache.ICACHE_ren), 32'h0);
    check("mrst_addr",  icache.ICACHE_addr, 32'h0);
    check("mrst_valid", 32'(ifid_valid), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_model();
    cycle(0, 0, 0, 32'h0, 32'hBAD0_0BAD);  // IDLE: must not be consumed
    check("mrst_noload", 32'(ifid_valid), 32'h0);
    cycle(0, 0, 0, 32'h0, 32'h0030_8213);
    check("mrst_first", ifid_instr, 32'h0030_8213);

    // ---- random traffic against the model ----
    for (int n = 0; n < 3000; n++) begin
      bit          st, sid, rd;
      logic [31:0] rpc;
      st  = ($urandom_range(0, 99) < 30);
      sid = ($urandom_range(0, 99) < 25);
      rd  = ($urandom_range(0, 99) < 8);
      rpc = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : $urandom;
      cycle(st, sid, rd, rpc, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_if_stage
